// File: rtl/gate_ack.sv
// gate_ack: responder side of the gate_en/gate_sync startup handshake, one stage switched at a time.
// Define GATE_ACK_SYNC_EN to pass gate_en_i through a 2-flop synchronizer.
module gate_ack #(
  parameter int N_GATE   = 5,
  parameter int SETTLE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [N_GATE-1:0]   gate_en_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  output logic [N_GATE-1:0]   gate_sw_o,
  output logic [N_GATE-1:0]   gate_sync_o,
  output logic                busy_o
);
  localparam int IDX_W = N_GATE > 1 ? $clog2(N_GATE) : 1;
  typedef enum logic {IDLE, WAIT} state_e;
  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d, low;
  logic [N_GATE-1:0]   sw_q, sw_d, sync_q, sync_d, en_s, mm;
`ifdef GATE_ACK_SYNC_EN
  logic [N_GATE-1:0] meta_q, en_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      meta_q <= '0;
      en_q   <= '0;
    end else begin
      meta_q <= gate_en_i;
      en_q   <= meta_q;
    end
  assign en_s = en_q;
`else
  assign en_s = gate_en_i;
`endif
  assign mm = en_s ^ sync_q;
  always_comb begin
    low = '0;
    for (int i = N_GATE - 1; i >= 0; i--) if (mm[i]) low = IDX_W'(i);
  end
  // the counter stops at zero, so the settle captured on entry to WAIT is never wrapped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sw_d    = sw_q;
    sync_d  = sync_q;
    if (state_q == IDLE) begin
      if (|mm) begin
        sw_d[low] = en_s[low];
        idx_d     = low;
        cnt_d     = settle_cycles_i;
        state_d   = WAIT;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end else begin
      sync_d[idx_q] = sw_q[idx_q];
      state_d       = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sw_q    <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sw_q    <= sw_d;
      sync_q  <= sync_d;
    end
  assign gate_sw_o   = sw_q;
  assign gate_sync_o = sync_q;
  assign busy_o      = state_q == WAIT;
endmodule

// File: tb/tb_gate_ack.sv
// tb_gate_ack: randomized and directed checks of gate_ack against a timestamp-based reference model.
module tb_gate_ack;
  localparam int N = 5;
  localparam int W = 16;
`ifdef GATE_ACK_SYNC_EN
  localparam int IN_LAT = 3;
`else
  localparam int IN_LAT = 1;
`endif
  logic         clk = 0;
  logic         rst_n = 0;
  logic [N-1:0] gate_en = '0;
  logic [W-1:0] settle = '0;
  logic [N-1:0] sw, sync;
  logic         busy;
  int checks = 0;
  int errors = 0;
  gate_ack #(.N_GATE(N), .SETTLE_W(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .gate_en_i(gate_en), .settle_cycles_i(settle),
    .gate_sw_o(sw), .gate_sync_o(sync), .busy_o(busy)
  );
  always #5 clk = ~clk;
  // reference: a transition started at cycle c completes at c+settle+1; free again one cycle later
  logic [N-1:0] m_sw = '0, m_sync = '0, h1 = '0, h2 = '0, m_en, m_mm;
  bit m_busy = 0;
  int cyc = 0, done_at = 0, m_idx = 0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_sw = '0; m_sync = '0; m_busy = 0; h1 = '0; h2 = '0; cyc = 0; done_at = 0;
    end else begin
`ifdef GATE_ACK_SYNC_EN
      m_en = h2; h2 = h1; h1 = gate_en;
`else
      m_en = gate_en;
`endif
      cyc++;
      if (m_busy) begin
        if (cyc == done_at) begin
          m_sync[m_idx] = m_sw[m_idx];
          m_busy = 0;
        end
      end else begin
        m_mm = m_en ^ m_sync;
        if (m_mm != '0) begin
          m_idx = 0;
          while (!m_mm[m_idx]) m_idx++;
          m_sw[m_idx] = m_en[m_idx];
          done_at = cyc + int'(settle) + 1;
          m_busy = 1;
        end
      end
    end
  end
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    gate_en = '0;
    settle = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    gate_en = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (sw !== '0) begin errors++; $display("FAIL reset_sw got %b want 00000", sw); end
    checks++;
    if (sync !== '0) begin errors++; $display("FAIL reset_sync got %b want 00000", sync); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask
  task automatic test_single();
    int t_sw = -1, t_sync = -1;
    apply_reset();
    settle = 99;
    gate_en = 5'b00001;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      checks++;
      if ({sw, sync, busy} !== {m_sw, m_sync, m_busy}) begin
        errors++;
        $display("FAIL single c=%0d got sw=%b sync=%b busy=%b want sw=%b sync=%b busy=%b", c, sw, sync, busy, m_sw, m_sync, m_busy);
      end
      if (t_sw < 0 && sw[0]) t_sw = c;
      if (t_sync < 0 && sync[0]) t_sync = c;
      if (t_sw > 0 && t_sync < 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy c=%0d got %b want 1", c, busy); end
      end
    end
    checks++;
    if (t_sw != IN_LAT) begin errors++; $display("FAIL single_sw_lat got %0d want %0d", t_sw, IN_LAT); end
    checks++;
    if (t_sync - t_sw != 100) begin errors++; $display("FAIL single_sync_lat got %0d want 100", t_sync - t_sw); end
  endtask
  task automatic test_all_on();
    int t_on[N];
    int t_full = -1;
    apply_reset();
    foreach (t_on[i]) t_on[i] = -1;
    settle = 3;
    gate_en = '1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if ({sw, sync, busy} !== {m_sw, m_sync, m_busy}) begin
        errors++;
        $display("FAIL all_on c=%0d got sw=%b sync=%b busy=%b want sw=%b sync=%b busy=%b", c, sw, sync, busy, m_sw, m_sync, m_busy);
      end
      for (int i = 0; i < N; i++) if (t_on[i] < 0 && sw[i]) t_on[i] = c;
      if (t_full < 0 && sync == '1) t_full = c;
    end
    for (int i = 1; i < N; i++) begin
      checks++;
      if (t_on[i] - t_on[i-1] != 5) begin errors++; $display("FAIL all_on_gap lane %0d got %0d want 5", i, t_on[i] - t_on[i-1]); end
    end
    checks++;
    if (t_full - t_on[0] != (N - 1) * 5 + 4) begin errors++; $display("FAIL all_on_full got %0d want %0d", t_full - t_on[0], (N - 1) * 5 + 4); end
  endtask
  task automatic test_closed_loop();
    int rises = 0;
    logic pb = 0;
    logic [N-1:0] ps = '0;
    apply_reset();
    settle = 99;
    gate_en = 5'b00001;
    for (int c = 1; c <= 1000 && sync != '1; c++) begin
      @(negedge clk);
      checks++;
      if ({sw, sync, busy} !== {m_sw, m_sync, m_busy}) begin
        errors++;
        $display("FAIL loop c=%0d got sw=%b sync=%b busy=%b want sw=%b sync=%b busy=%b", c, sw, sync, busy, m_sw, m_sync, m_busy);
      end
      checks++;
      if ($countones(sw ^ ps) > 1) begin errors++; $display("FAIL loop_one_lane c=%0d got %b from %b", c, sw, ps); end
      if (busy && !pb) rises++;
      pb = busy;
      ps = sw;
      if (sync == gate_en && gate_en != '1) gate_en = {gate_en[N-2:0], 1'b1};
    end
    checks++;
    if (sync !== '1) begin errors++; $display("FAIL loop_done got %b want 11111", sync); end
    checks++;
    if (rises != N) begin errors++; $display("FAIL loop_windows got %0d want %0d", rises, N); end
  endtask
  task automatic test_settle0();
    int t_sw = -1, t_sync = -1;
    apply_reset();
    settle = 0;
    gate_en = 5'b00100;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if ({sw, sync, busy} !== {m_sw, m_sync, m_busy}) begin
        errors++;
        $display("FAIL settle0 c=%0d got sw=%b sync=%b busy=%b want sw=%b sync=%b busy=%b", c, sw, sync, busy, m_sw, m_sync, m_busy);
      end
      if (t_sw < 0 && sw[2]) t_sw = c;
      if (t_sync < 0 && sync[2]) t_sync = c;
    end
    checks++;
    if (t_sync - t_sw != 1 || t_sw < 0) begin errors++; $display("FAIL settle0_lat got %0d want 1", t_sync - t_sw); end
  endtask
  task automatic test_reversal();
    int t_on = -1, t_son = -1, t_off = -1, t_soff = -1;
    logic psw = 0, psy = 0;
    apply_reset();
    settle = 10;
    gate_en = 5'b00010;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if ({sw, sync, busy} !== {m_sw, m_sync, m_busy}) begin
        errors++;
        $display("FAIL reversal c=%0d got sw=%b sync=%b busy=%b want sw=%b sync=%b busy=%b", c, sw, sync, busy, m_sw, m_sync, m_busy);
      end
      if (t_on < 0 && sw[1] && !psw) t_on = c;
      if (t_son < 0 && sync[1] && !psy) t_son = c;
      if (t_off < 0 && !sw[1] && psw) t_off = c;
      if (t_soff < 0 && !sync[1] && psy) t_soff = c;
      psw = sw[1];
      psy = sync[1];
      if (c == 5) begin
        gate_en = '0;
        settle = 2;
      end
    end
    checks++;
    if (t_son - t_on != 11) begin errors++; $display("FAIL rev_on_lat got %0d want 11", t_son - t_on); end
    checks++;
    if (t_off - t_son != 1) begin errors++; $display("FAIL rev_idle got %0d want 1", t_off - t_son); end
    checks++;
    if (t_soff - t_off != 3) begin errors++; $display("FAIL rev_off_lat got %0d want 3", t_soff - t_off); end
  endtask
  task automatic test_reset_mid();
    logic [N-1:0] first = '0;
    apply_reset();
    settle = 50;
    gate_en = 5'b00011;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    rst_n = 0;
    #1;
    checks++;
    if ({sw, sync, busy} !== '0) begin errors++; $display("FAIL mid_async got sw=%b sync=%b busy=%b want all 0", sw, sync, busy); end
    @(negedge clk);
    rst_n = 1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      checks++;
      if ({sw, sync, busy} !== {m_sw, m_sync, m_busy}) begin
        errors++;
        $display("FAIL mid c=%0d got sw=%b sync=%b busy=%b want sw=%b sync=%b busy=%b", c, sw, sync, busy, m_sw, m_sync, m_busy);
      end
      if (first == '0) first = sw;
    end
    checks++;
    if (first !== 5'b00001) begin errors++; $display("FAIL mid_restart got %b want 00001", first); end
  endtask
  task automatic test_random();
    apply_reset();
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk);
      checks++;
      if ({sw, sync, busy} !== {m_sw, m_sync, m_busy}) begin
        errors++;
        $display("FAIL random c=%0d got sw=%b sync=%b busy=%b want sw=%b sync=%b busy=%b", c, sw, sync, busy, m_sw, m_sync, m_busy);
      end
      if ($urandom_range(0, 7) == 0) gate_en = N'($urandom);
      settle = W'($urandom_range(0, 6));
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_all_on();
    test_closed_loop();
    test_settle0();
    test_reversal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
